// File: rtl/simple_module_pkg.sv
// rtl/simple_module_pkg.sv - shared gate-op enum, gate evaluation function and default counter width
package simple_module_pkg;

  typedef enum logic [2:0] {
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NAND,
    OP_NOR,
    OP_XNOR
  } op_e;

  localparam int unsigned CNT_W_DEFAULT = 16;

  function automatic logic gate_eval(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      default: r = ~(a ^ b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/simple_module_edge.sv
// rtl/simple_module_edge.sv - registers the gate result and derives one-cycle rise/fall pulses
module simple_module_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic y,
  output logic y_q,
  output logic y_rise,
  output logic y_fall
);

  logic cur_q, cur_d;
  logic prev_q, prev_d;

  assign cur_d  = y;
  assign prev_d = cur_q;

  // prev_q clears with cur_q, so a 1 loaded on the first edge after reset reports a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  assign y_q    = cur_q;
  assign y_rise = cur_q & ~prev_q;
  assign y_fall = ~cur_q & prev_q;

endmodule

// File: rtl/simple_module.sv
// rtl/simple_module.sv - 2-input gate with registered copy, edge pulses and rise counter (SIMPLE_MODULE_STATS_EN)
module simple_module
  import simple_module_pkg::*;
#(
  parameter string       OP    = "AND",
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cnt_clr,
  output logic y,
  output logic y_q,
  output logic y_rise,
  output logic y_fall
`ifdef SIMPLE_MODULE_STATS_EN
 ,output logic [CNT_W-1:0] y_cnt
`endif
);

  localparam bit OP_OK = (OP == "AND") || (OP == "OR") || (OP == "XOR") ||
                         (OP == "NAND") || (OP == "NOR") || (OP == "XNOR");

  localparam op_e OP_SEL = (OP == "OR")   ? OP_OR   :
                           (OP == "XOR")  ? OP_XOR  :
                           (OP == "NAND") ? OP_NAND :
                           (OP == "NOR")  ? OP_NOR  :
                           (OP == "XNOR") ? OP_XNOR : OP_AND;

  if (!OP_OK) begin : g_bad_op
    $error("simple_module: unsupported OP value");
  end

  assign y = gate_eval(OP_SEL, a, b);

  logic rise;

  simple_module_edge u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .y      (y),
    .y_q    (y_q),
    .y_rise (rise),
    .y_fall (y_fall)
  );

  assign y_rise = rise;

`ifdef SIMPLE_MODULE_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clear wins over increment; the count holds once it reaches all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign y_cnt = cnt_q;
`else
  logic [CNT_W:0] unused_stats;
  assign unused_stats = {cnt_clr, {CNT_W{1'b0}}};
`endif

endmodule

// File: tb/tb_simple_module.sv
// tb/tb_simple_module.sv - self-checking bench for simple_module
module tb_simple_module;

  typedef struct {
    logic       a;
    logic       b;
    logic [0:5] y_all;  // AND, OR, XOR, NAND, NOR, XNOR
  } vec_t;

  vec_t vecs [4];

  logic clk = 1'b0;
  bit   clk_run = 1'b0;
  logic rst_n, a, b, cnt_clr;
  logic y, y_q, y_rise, y_fall;
  logic s_y, s_yq, s_rise, s_fall;
  logic [4:0] g_y, g_yq, g_rise, g_fall;
`ifdef SIMPLE_MODULE_STATS_EN
  logic [15:0] y_cnt;
  logic [2:0]  s_cnt;
  logic [15:0] g_cnt [5];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bit m_cur, m_prev, m_rise, m_fall;
  int m_cnt16, m_cnt3;

  always #5 if (clk_run) clk = ~clk;

  simple_module #(.OP("AND"), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cnt_clr(cnt_clr),
    .y(y), .y_q(y_q), .y_rise(y_rise), .y_fall(y_fall)
`ifdef SIMPLE_MODULE_STATS_EN
   ,.y_cnt(y_cnt)
`endif
  );

  simple_module #(.OP("AND"), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cnt_clr(cnt_clr),
    .y(s_y), .y_q(s_yq), .y_rise(s_rise), .y_fall(s_fall)
`ifdef SIMPLE_MODULE_STATS_EN
   ,.y_cnt(s_cnt)
`endif
  );

  for (genvar i = 0; i < 5; i++) begin : g_ops
    localparam string NAME = (i == 0) ? "OR"   :
                             (i == 1) ? "XOR"  :
                             (i == 2) ? "NAND" :
                             (i == 3) ? "NOR"  : "XNOR";
    simple_module #(.OP(NAME)) u_op (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cnt_clr(cnt_clr),
      .y(g_y[i]), .y_q(g_yq[i]), .y_rise(g_rise[i]), .y_fall(g_fall[i])
`ifdef SIMPLE_MODULE_STATS_EN
     ,.y_cnt(g_cnt[i])
`endif
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ref_y(input int op, input logic ia, input logic ib);
    return vecs[{ia, ib}].y_all[op];
  endfunction

  task automatic model_reset();
    m_cur = 0; m_prev = 0; m_rise = 0; m_fall = 0;
    m_cnt16 = 0; m_cnt3 = 0;
  endtask

  task automatic check_regs();
    chk("y_q", y_q, m_cur);
    chk("y_rise", y_rise, m_rise);
    chk("y_fall", y_fall, m_fall);
    chk("rise_fall_excl", y_rise & y_fall, 0);
    chk("sat_y_q", s_yq, m_cur);
`ifdef SIMPLE_MODULE_STATS_EN
    chk("y_cnt", y_cnt, m_cnt16);
    chk("sat_y_cnt", s_cnt, m_cnt3);
`endif
  endtask

  task automatic check_comb();
    chk("y_and", y, ref_y(0, a, b));
    for (int k = 0; k < 5; k++) chk("y_op", g_y[k], ref_y(k + 1, a, b));
  endtask

  // a glitch value is shown first, then the settled value that the edge must capture
  task automatic cycle(input logic na, input logic nb, input logic clr);
    a = 1'($urandom); b = 1'($urandom); cnt_clr = clr;
    #1;
    check_comb();
    a = na; b = nb;
    #1;
    check_comb();
    @(posedge clk);
    if (clr) begin
      m_cnt16 = 0; m_cnt3 = 0;
    end else if (m_rise) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt3 < 7) m_cnt3++;
    end
    m_prev = m_cur;
    m_cur  = ref_y(0, na, nb);
    m_rise = m_cur && !m_prev;
    m_fall = !m_cur && m_prev;
    #1;
    check_regs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 6'b000111};
    vecs[1] = '{1'b0, 1'b1, 6'b011100};
    vecs[2] = '{1'b1, 1'b0, 6'b011100};
    vecs[3] = '{1'b1, 1'b1, 6'b110001};

    rst_n = 1'b0; a = 1'b0; b = 1'b0; cnt_clr = 1'b0;
    model_reset();

    // clock idle, reset held: outputs combinational only
    for (int i = 0; i < 4; i++) begin
      a = vecs[i].a; b = vecs[i].b;
      #10;
      chk("rst_y_and", y, vecs[i].y_all[0]);
      for (int k = 0; k < 5; k++) chk("rst_y_op", g_y[k], vecs[i].y_all[k + 1]);
      check_regs();
    end

    a = 1'b1; b = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1'b1, 1'b1, 1'b0);
    chk("first_edge_rise", y_rise, 1);
    cycle(1'b1, 1'b1, 1'b0);
    chk("rise_one_cycle", y_rise, 0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("fall_pulse", y_fall, 1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("fall_one_cycle", y_fall, 0);

    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
`ifdef SIMPLE_MODULE_STATS_EN
    chk("cnt_toggle5", y_cnt, 5);
`endif

    cycle(1'b1, 1'b1, 1'b0);
    chk("rise_before_clr", y_rise, 1);
    cycle(1'b1, 1'b1, 1'b1);
`ifdef SIMPLE_MODULE_STATS_EN
    chk("clr_beats_inc", y_cnt, 0);
`endif

    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
`ifdef SIMPLE_MODULE_STATS_EN
    chk("sat_cnt_w3", s_cnt, 7);
    chk("cnt_nine", y_cnt, 9);
`endif

    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("y_q_before_rst", y_q, 1);
`ifdef SIMPLE_MODULE_STATS_EN
    chk("cnt_before_rst", y_cnt, 4);
`endif
    #2;
    rst_n = 1'b0;
    a = 1'b0; b = 1'b1;
    #1;
    model_reset();
    chk("async_rst_y_q", y_q, 0);
    check_regs();
    chk("rst_y_follow", y, ref_y(0, 1'b0, 1'b1));
    for (int k = 0; k < 5; k++) chk("rst_y_op_follow", g_y[k], ref_y(k + 1, 1'b0, 1'b1));

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_module.md
SIMPLE_MODULE -- requirements
Module: simple_module

Interface
REQ-001 Parameter OP, default "AND"; selects the 2-input function: AND, OR, XOR, NAND, NOR or XNOR.
REQ-002 Parameter CNT_W, default 16; width of the rise-event counter.
REQ-003 clk  input  1  single clock; all sequential logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a  input  1  operand A.
REQ-006 b  input  1  operand B.
REQ-007 cnt_clr  input  1  synchronous clear of the event counter.
REQ-008 y  output  1  combinational result f(a,b).
REQ-009 y_q  output  1  registered copy of y.
REQ-010 y_rise  output  1  one-cycle pulse on a 0->1 change of y_q.
REQ-011 y_fall  output  1  one-cycle pulse on a 1->0 change of y_q.
REQ-012 y_cnt  output  CNT_W  count of y_rise pulses (present only with the macro).

Function
REQ-013 y SHALL be purely combinational from a and b, with zero-cycle latency and no dependence on clk or rst_n.
REQ-014 With OP=AND: y SHALL be 0,0,0,1 for (a,b) = 00, 01, 10, 11.
REQ-015 The other OP values SHALL produce the standard truth table of the named gate.
REQ-016 Elaboration SHALL fail on an unsupported OP value.
REQ-017 y_q SHALL capture y on each rising clk edge (latency 1 cycle).
REQ-018 y_rise SHALL equal y_q AND NOT y_q_prev, where y_q_prev is y_q delayed one cycle.
REQ-019 y_fall SHALL equal NOT y_q AND y_q_prev.
REQ-020 y_rise and y_fall SHALL never both be 1.
REQ-021 On y_rise, y_cnt SHALL increment by 1.
REQ-022 y_cnt SHALL saturate at all-ones with no wrap-around.
REQ-023 cnt_clr SHALL take priority over an increment in the same cycle; the result is 0.
REQ-024 Glitches on a or b between clock edges SHALL affect y only, not the registered outputs.

Reset
REQ-025 While rst_n is low: y_q=0, y_q_prev=0, y_rise=0, y_fall=0 and y_cnt=0, asynchronously.
REQ-026 y SHALL keep following a and b during reset.
REQ-027 Reset deassertion is synchronised by the system. The first edge after release SHALL load y_q normally.
REQ-028 When the first loaded y_q is 1, y_rise SHALL pulse on that cycle.
REQ-029 Reset asserted mid-count SHALL zero y_cnt immediately.

Configuration
REQ-030 Macro SIMPLE_MODULE_STATS_EN defined: the y_cnt port, its counter and cnt_clr handling SHALL be present.
REQ-031 Macro SIMPLE_MODULE_STATS_EN undefined: y_cnt and its counter SHALL be omitted; cnt_clr SHALL remain as an ignored input.
REQ-032 In both cases, all other behaviour SHALL be identical.

Structure
REQ-033 Shared package simple_module_pkg SHALL hold the op_e enum (AND, OR, XOR, NAND, NOR, XNOR).
REQ-034 simple_module_pkg SHALL hold the gate-evaluation function.
REQ-035 simple_module_pkg SHALL hold the default CNT_W constant.
REQ-036 Sub-module simple_module_edge SHALL contain the y_q/y_q_prev registers and the rise/fall detection.
REQ-037 The counter SHALL stay in the top level.

Verification
REQ-038 OP=AND, clk idle, rst_n=0; apply (a,b) = 00, 01, 10, 11 for 10 time units each -> y = 0, 0, 0, 1.
REQ-039 Out of reset, (a,b) 00->11 held 1 cycle -> y_q=1 one cycle later and y_rise=1 for exactly 1 cycle; then 11->00 -> y_fall pulses once.
REQ-040 Toggle (a,b) between 00 and 11 every 2 cycles, 5 times -> y_cnt=5.
REQ-041 Assert cnt_clr on the same cycle as a y_rise -> y_cnt=0.
REQ-042 CNT_W=3, 9 rises -> y_cnt stays 7.
REQ-043 Assert rst_n=0 between clock edges while y_cnt=4 -> y_cnt=0 and y_q=0 without waiting for a clk edge.
REQ-044 Sweep OP over XOR, NOR and XNOR with all 4 (a,b) inputs -> y = 0110, 1000 and 1001 respectively.
